sd_sector_buffer: RTL and testbench

- Sits directly downstream of the SD SPI sector reader and consumes its byte stream (data byte, byte clock, data-block enable).
- Stores each 512-byte sector into one half of a ping-pong RAM (2 banks x 512 x 8) and hands full banks to the video/frame consumer through a ready/release handshake.
- Drives the sector address that the reader latches for its next CMD17, walking through a frame's sectors and wrapping at the frame end.

---
 rtl/sd_sector_buffer_if.sv | 25 ++
 rtl/sd_sector_buffer.sv | 173 +++++++++++++++++
 tb/tb_sd_sector_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_buffer_if.sv
// Consumer-side read port of the SD sector ping-pong buffer.
// The consumer (master) addresses bytes and releases banks; the buffer (slave) returns data and bank status.
interface sd_sector_buffer_if;
    logic [8:0] ReadAddr;
    logic [7:0] ReadData;
    logic       BankReady;
    logic       BankRelease;
    logic       ActiveBank;

    modport master (
        output ReadAddr,
        output BankRelease,
        input  ReadData,
        input  BankReady,
        input  ActiveBank
    );

    modport slave (
        input  ReadAddr,
        input  BankRelease,
        output ReadData,
        output BankReady,
        output ActiveBank
    );
endinterface

// File: rtl/sd_sector_buffer.sv
// Ping-pong sector buffer between the SD SPI sector reader and the frame consumer.
// It captures 512-byte blocks into alternating banks and walks the reader's sector address through a frame.
module sd_sector_buffer #(
    parameter int SECTOR_BYTES  = 512,
    parameter int START_SECTOR  = 0,
    parameter int FRAME_SECTORS = 150,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic                  MasterCLK,
    input  logic                  Reset,
    input  logic [7:0]            InputData,
    input  logic                  InputDataClock,
    input  logic                  EnableVideoRead,
    output logic [ADDR_WIDTH-1:0] InputAddress,
    output logic                  FrameDone,
    output logic                  Overrun,
    output logic                  ShortBlock,
    sd_sector_buffer_if.slave     rd
);

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0]      SECTOR_CNT = CNT_W'(SECTOR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(START_SECTOR);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(START_SECTOR + FRAME_SECTORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DISCARD = 2'd2
    } wr_state_t;

    logic [2:0]            bclk_sync_r;
    logic [2:0]            en_sync_r;
    logic [1:0]            fill_r;
    logic                  armed_r;
    wr_state_t             state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  wr_bank_r;
    logic                  active_r;
    logic [1:0]            full_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  frame_done_r;
    logic                  overrun_r;
    logic                  short_r;
    logic [7:0]            read_data_r;
    logic [7:0]            mem [0:1023];

    logic                  bclk_rise_s;
    logic                  en_rise_s;
    logic                  en_fall_s;
    logic                  sector_full_s;
    logic                  wr_en_s;
    logic                  release_s;
    logic                  last_sector_s;
    logic [9:0]            wr_addr_s;

    // Edge decode, write enable and release qualification from registered state.
    always_comb begin
        bclk_rise_s   = bclk_sync_r[1] & ~bclk_sync_r[2];
        en_rise_s     = en_sync_r[1] & ~en_sync_r[2];
        en_fall_s     = ~en_sync_r[1] & en_sync_r[2];
        sector_full_s = (cnt_r == SECTOR_CNT);
        wr_en_s       = Reset && (state_r == ST_CAPTURE) && bclk_rise_s && !en_fall_s
                        && (cnt_r < SECTOR_CNT);
        release_s     = rd.BankRelease & full_r[active_r];
        last_sector_s = (addr_r == LAST_ADDR);
        wr_addr_s     = {wr_bank_r, cnt_r[8:0]};
    end

    // Synchronizers; fill_r marks when the second stage holds a real sample after reset.
    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            bclk_sync_r <= 3'b000;
            en_sync_r   <= 3'b000;
            fill_r      <= 2'b00;
        end else begin
            bclk_sync_r <= {bclk_sync_r[1:0], InputDataClock};
            en_sync_r   <= {en_sync_r[1:0], EnableVideoRead};
            fill_r      <= {fill_r[0], 1'b1};
        end
    end

    // Write FSM, bank bookkeeping, sector address and status flags.
    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            state_r      <= ST_IDLE;
            armed_r      <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            wr_bank_r    <= 1'b0;
            active_r     <= 1'b0;
            full_r       <= 2'b00;
            addr_r       <= FIRST_ADDR;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            short_r      <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (fill_r[1] && !en_sync_r[1]) begin
                armed_r <= 1'b1;
            end
            // A completing bank never equals the bank being released: it was empty when capture began.
            if (release_s) begin
                full_r[active_r] <= 1'b0;
                active_r         <= ~active_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (en_rise_s && armed_r) begin
                        if (full_r[wr_bank_r]) begin
                            state_r   <= ST_DISCARD;
                            overrun_r <= 1'b1;
                        end else begin
                            state_r <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (en_fall_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                        if (sector_full_s) begin
                            full_r[wr_bank_r] <= 1'b1;
                            wr_bank_r         <= ~wr_bank_r;
                            if (last_sector_s) begin
                                addr_r       <= FIRST_ADDR;
                                frame_done_r <= 1'b1;
                            end else begin
                                addr_r <= addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            short_r <= 1'b1;
                        end
                    end else if (wr_en_s) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DISCARD: begin
                    if (en_fall_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sector RAM write port; contents survive reset.
    always_ff @(posedge MasterCLK) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= InputData;
        end
    end

    // Registered consumer read port.
    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            read_data_r <= 8'h00;
        end else begin
            read_data_r <= mem[{active_r, rd.ReadAddr}];
        end
    end

    assign InputAddress = addr_r;
    assign FrameDone    = frame_done_r;
    assign Overrun      = overrun_r;
    assign ShortBlock   = short_r;
    assign rd.ReadData  = read_data_r;
    assign rd.BankReady = full_r[active_r];
    assign rd.ActiveBank = active_r;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Self-checking bench for sd_sector_buffer: a reference model of banks, flags and address,
// with read data checked through an expected-value queue.
module tb_sd_sector_buffer;

    localparam int START = 0;
    localparam int FRAME = 3;

    logic        clk = 1'b0;
    logic        Reset;
    logic [7:0]  InputData;
    logic        InputDataClock;
    logic        EnableVideoRead;
    logic [15:0] InputAddress;
    logic        FrameDone;
    logic        Overrun;
    logic        ShortBlock;

    sd_sector_buffer_if bus ();

    sd_sector_buffer #(
        .SECTOR_BYTES (512),
        .START_SECTOR (START),
        .FRAME_SECTORS(FRAME),
        .ADDR_WIDTH   (16)
    ) dut (
        .MasterCLK      (clk),
        .Reset          (Reset),
        .InputData      (InputData),
        .InputDataClock (InputDataClock),
        .EnableVideoRead(EnableVideoRead),
        .InputAddress   (InputAddress),
        .FrameDone      (FrameDone),
        .Overrun        (Overrun),
        .ShortBlock     (ShortBlock),
        .rd             (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int fd_count    = 0;

    logic [7:0] mdl_mem [0:1][0:511];
    bit         mdl_full [0:1];
    bit         mdl_wr;
    bit         mdl_active;
    int         mdl_addr;
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        if (FrameDone === 1'b1) fd_count++;
    end

    function automatic logic [7:0] pat(int seed, int i);
        return 8'(i) ^ 8'(seed) ^ ((i >= 512) ? 8'h5A : 8'h00);
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mdl_reset();
        mdl_full[0] = 1'b0;
        mdl_full[1] = 1'b0;
        mdl_wr      = 1'b0;
        mdl_active  = 1'b0;
        mdl_addr    = START;
    endtask

    task automatic do_reset();
        Reset           = 1'b0;
        InputDataClock  = 1'b0;
        EnableVideoRead = 1'b0;
        InputData       = 8'h00;
        bus.ReadAddr    = 9'h000;
        bus.BankRelease = 1'b0;
        cyc(3);
        Reset = 1'b1;
        cyc(6);
        mdl_reset();
    endtask

    task automatic strobe(logic [7:0] d);
        InputData = d;
        cyc(1);
        InputDataClock = 1'b1;
        cyc(3);
        InputDataClock = 1'b0;
        cyc(2);
    endtask

    task automatic send_block(int n, int seed);
        EnableVideoRead = 1'b1;
        cyc(4);
        for (int i = 0; i < n; i++) strobe(pat(seed, i));
        cyc(2);
        EnableVideoRead = 1'b0;
        cyc(6);
        if (mdl_full[mdl_wr]) begin
            // discarded block: nothing changes in the model beyond the sticky flag
        end else if (n >= 512) begin
            for (int i = 0; i < 512; i++) mdl_mem[mdl_wr][i] = pat(seed, i);
            mdl_full[mdl_wr] = 1'b1;
            mdl_wr = ~mdl_wr;
            mdl_addr = (mdl_addr == START + FRAME - 1) ? START : mdl_addr + 1;
        end
    endtask

    task automatic release_bank();
        bus.BankRelease = 1'b1;
        cyc(1);
        bus.BankRelease = 1'b0;
        if (mdl_full[mdl_active]) begin
            mdl_full[mdl_active] = 1'b0;
            mdl_active = ~mdl_active;
        end
        cyc(1);
    endtask

    task automatic rd(logic [8:0] a, output logic [7:0] got);
        bus.ReadAddr = a;
        exp_q.push_back(mdl_mem[mdl_active][a]);
        cyc(1);
        got = bus.ReadData;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (InputAddress !== 16'(START)) begin
            miscompares++; $display("FAIL reset_addr got=%h exp=%h", InputAddress, 16'(START));
        end
        vectors++;
        if ({bus.ReadData, bus.BankReady, bus.ActiveBank, FrameDone, Overrun, ShortBlock} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got data=%h rdy=%b act=%b fd=%b ovr=%b sb=%b exp all zero",
                     bus.ReadData, bus.BankReady, bus.ActiveBank, FrameDone, Overrun, ShortBlock);
        end
    endtask

    task automatic test_single_block();
        logic [7:0] got, exp;
        do_reset();
        send_block(512, 0);
        vectors++;
        if ({bus.BankReady, bus.ActiveBank} !== 2'b10) begin
            miscompares++; $display("FAIL single_ready got=%b%b exp=10", bus.BankReady, bus.ActiveBank);
        end
        vectors++;
        if (InputAddress !== 16'(START + 1)) begin
            miscompares++; $display("FAIL single_addr got=%0d exp=%0d", InputAddress, START + 1);
        end
        rd(9'h1FF, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== 8'hFF || got !== exp) begin
            miscompares++; $display("FAIL single_rd_1ff got=%h exp=ff", got);
        end
        for (int a = 0; a < 512; a += 61) begin
            rd(9'(a), got);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++; $display("FAIL single_rd addr=%h got=%h exp=%h", a, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, exp;
        do_reset();
        send_block(512, 8'h11);
        send_block(512, 8'h22);
        vectors++;
        if (InputAddress !== 16'(START + 2) || bus.BankReady !== 1'b1) begin
            miscompares++; $display("FAIL b2b_two got addr=%0d rdy=%b exp addr=%0d rdy=1", InputAddress, bus.BankReady, START + 2);
        end
        send_block(512, 8'h33);
        vectors++;
        if (Overrun !== 1'b1 || InputAddress !== 16'(START + 2)) begin
            miscompares++; $display("FAIL b2b_overrun got ovr=%b addr=%0d exp ovr=1 addr=%0d", Overrun, InputAddress, START + 2);
        end
        for (int a = 0; a < 512; a += 47) begin
            rd(9'(a), got);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++; $display("FAIL b2b_bank0 addr=%h got=%h exp=%h", a, got, exp);
            end
        end
        release_bank();
        vectors++;
        if ({bus.BankReady, bus.ActiveBank} !== 2'b11) begin
            miscompares++; $display("FAIL b2b_release got rdy/act=%b%b exp=11", bus.BankReady, bus.ActiveBank);
        end
        for (int a = 3; a < 512; a += 101) begin
            rd(9'(a), got);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++; $display("FAIL b2b_bank1 addr=%h got=%h exp=%h", a, got, exp);
            end
        end
        release_bank();
        vectors++;
        if ({bus.BankReady, bus.ActiveBank} !== 2'b00) begin
            miscompares++; $display("FAIL b2b_release2 got rdy/act=%b%b exp=00", bus.BankReady, bus.ActiveBank);
        end
    endtask

    task automatic test_short_block();
        logic [7:0] got, exp;
        do_reset();
        send_block(300, 8'h44);
        vectors++;
        if (ShortBlock !== 1'b1 || bus.BankReady !== 1'b0 || InputAddress !== 16'(START)) begin
            miscompares++; $display("FAIL short_flags got sb=%b rdy=%b addr=%0d exp sb=1 rdy=0 addr=%0d", ShortBlock, bus.BankReady, InputAddress, START);
        end
        send_block(512, 8'h55);
        vectors++;
        if ({bus.BankReady, bus.ActiveBank} !== 2'b10 || InputAddress !== 16'(START + 1)) begin
            miscompares++; $display("FAIL short_next got rdy/act=%b%b addr=%0d exp 10 addr=%0d", bus.BankReady, bus.ActiveBank, InputAddress, START + 1);
        end
        for (int a = 0; a < 512; a += 73) begin
            rd(9'(a), got);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++; $display("FAIL short_rd addr=%h got=%h exp=%h", a, got, exp);
            end
        end
    endtask

    task automatic test_long_block();
        logic [7:0] got, exp;
        do_reset();
        send_block(520, 8'h66);
        vectors++;
        if (bus.BankReady !== 1'b1 || InputAddress !== 16'(START + 1) || ShortBlock !== 1'b0 || Overrun !== 1'b0) begin
            miscompares++; $display("FAIL long_accept got rdy=%b addr=%0d sb=%b ovr=%b exp rdy=1 addr=%0d sb=0 ovr=0", bus.BankReady, InputAddress, ShortBlock, Overrun, START + 1);
        end
        for (int a = 0; a < 10; a++) begin
            rd(9'(a), got);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++; $display("FAIL long_rd addr=%h got=%h exp=%h", a, got, exp);
            end
        end
        rd(9'h1FF, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL long_rd_1ff got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_frame_wrap();
        int exp_addr [0:2] = '{START + 1, START + 2, START};
        int exp_fd   [0:2] = '{0, 0, 1};
        int base;
        do_reset();
        base = fd_count;
        for (int k = 0; k < 3; k++) begin
            send_block(512, k * 7 + 1);
            vectors++;
            if (InputAddress !== 16'(exp_addr[k]) || (fd_count - base) != exp_fd[k]) begin
                miscompares++; $display("FAIL frame_step%0d got addr=%0d fd=%0d exp addr=%0d fd=%0d", k, InputAddress, fd_count - base, exp_addr[k], exp_fd[k]);
            end
            release_bank();
        end
        cyc(4);
        vectors++;
        if ((fd_count - base) != 1 || Overrun !== 1'b0) begin
            miscompares++; $display("FAIL frame_final got fd=%0d ovr=%b exp fd=1 ovr=0", fd_count - base, Overrun);
        end
    endtask

    task automatic test_reset_mid_block();
        logic [7:0] got, exp;
        do_reset();
        EnableVideoRead = 1'b1;
        cyc(4);
        for (int i = 0; i < 100; i++) strobe(pat(8'h88, i));
        Reset = 1'b0;
        cyc(2);
        Reset = 1'b1;
        mdl_reset();
        for (int i = 100; i < 150; i++) strobe(pat(8'h88, i));
        cyc(2);
        EnableVideoRead = 1'b0;
        cyc(6);
        vectors++;
        if ({ShortBlock, Overrun, bus.BankReady} !== 3'b000 || InputAddress !== 16'(START)) begin
            miscompares++; $display("FAIL midrst_flags got sb=%b ovr=%b rdy=%b addr=%0d exp 0 0 0 addr=%0d", ShortBlock, Overrun, bus.BankReady, InputAddress, START);
        end
        send_block(512, 8'h99);
        vectors++;
        if ({bus.BankReady, bus.ActiveBank} !== 2'b10 || InputAddress !== 16'(START + 1)) begin
            miscompares++; $display("FAIL midrst_next got rdy/act=%b%b addr=%0d exp 10 addr=%0d", bus.BankReady, bus.ActiveBank, InputAddress, START + 1);
        end
        for (int a = 0; a < 512; a += 53) begin
            rd(9'(a), got);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++; $display("FAIL midrst_rd addr=%h got=%h exp=%h", a, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_short_block();
        test_long_block();
        test_frame_wrap();
        test_reset_mid_block();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
